pkt_hold_buffer: RTL and testbench

- Store-and-forward packet buffer for the NetFPGA user data path.
- Captures one complete packet from the 64-bit ctrl/data stream into on-chip memory, then holds it until software releases it downstream or drops it.
- Successor to the single-packet CPU-hold stage: depth, width and release mode are parametrised, with added packet-length reporting, overflow truncation and drop handling, and forward/drop statistics.
- Sits between the input arbiter side of the user data path and the output port lookup.

---
 rtl/pkt_hold_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_pkt_hold_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_hold_buffer.sv
// Store-and-forward hold buffer: captures one framed packet, holds it for release/drop, then replays it.
// Output word appears one cycle after a read issued under out_rdy_i; input accepted only while in_rdy_o.
module pkt_hold_buffer #(
   parameter int DATA_WIDTH   = 64,
   parameter int CTRL_WIDTH   = DATA_WIDTH/8,
   parameter int ADDR_WIDTH   = 8,
   parameter bit AUTO_RELEASE = 1'b0
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [DATA_WIDTH-1:0]            in_data_i,
   input  logic [CTRL_WIDTH-1:0]            in_ctrl_i,
   input  logic                             in_wr_i,
   output logic                             in_rdy_o,
   output logic [DATA_WIDTH-1:0]            out_data_o,
   output logic [CTRL_WIDTH-1:0]            out_ctrl_o,
   output logic                             out_wr_o,
   input  logic                             out_rdy_i,
   input  logic                             cmd_release_i,
   input  logic                             cmd_drop_i,
   output logic                             pkt_held_o,
   output logic [ADDR_WIDTH:0]              held_len_o,
   input  logic [ADDR_WIDTH-1:0]            cpu_addr_i,
   output logic [CTRL_WIDTH+DATA_WIDTH-1:0] cpu_rd_data_o,
   output logic [31:0]                      pkt_fwd_cnt_o,
   output logic [31:0]                      pkt_drop_cnt_o,
   output logic [31:0]                      ovfl_drop_cnt_o
);

   localparam int WW = CTRL_WIDTH + DATA_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_PAYLOAD, S_HOLD, S_SEND, S_OVFL
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_WIDTH:0] wr_cnt_q, wr_cnt_d;
   logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
   logic                pay_q, pay_d;
   logic [31:0]         fwd_cnt_q, fwd_cnt_d;
   logic [31:0]         drop_cnt_q, drop_cnt_d;
   logic [31:0]         ovfl_cnt_q, ovfl_cnt_d;
   logic                in_rdy_q, in_rdy_d;
   logic                held_q, held_d;
   logic [ADDR_WIDTH:0] held_len_q, held_len_d;
   logic                out_wr_q, out_last_q;
   logic [WW-1:0]       out_word_q, cpu_word_q;

   logic [WW-1:0]       mem [2**ADDR_WIDTH];
   logic                mem_we, rd_en, rd_last, ctrl_nz, buf_full;

   assign ctrl_nz  = |in_ctrl_i;
   // The count's top bit is set only when every location is occupied.
   assign buf_full = wr_cnt_q[ADDR_WIDTH];
   assign rd_last  = (rd_ptr_q == (wr_cnt_q - CNT_ONE));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         wr_cnt_q   <= '0;
         rd_ptr_q   <= '0;
         pay_q      <= 1'b0;
         fwd_cnt_q  <= '0;
         drop_cnt_q <= '0;
         ovfl_cnt_q <= '0;
         in_rdy_q   <= 1'b0;
         held_q     <= 1'b0;
         held_len_q <= '0;
         out_wr_q   <= 1'b0;
         out_last_q <= 1'b0;
         out_word_q <= '0;
         cpu_word_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         pay_q      <= pay_d;
         fwd_cnt_q  <= fwd_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         ovfl_cnt_q <= ovfl_cnt_d;
         in_rdy_q   <= in_rdy_d;
         held_q     <= held_d;
         held_len_q <= held_len_d;
         out_wr_q   <= rd_en;
         out_last_q <= rd_en && rd_last;
         if (rd_en) begin
            out_word_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
         end
         cpu_word_q <= mem[cpu_addr_i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem[wr_cnt_q[ADDR_WIDTH-1:0]] <= {in_ctrl_i, in_data_i};
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_cnt_d   = wr_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      pay_d      = pay_q;
      fwd_cnt_d  = fwd_cnt_q;
      drop_cnt_d = drop_cnt_q;
      ovfl_cnt_d = ovfl_cnt_q;
      mem_we     = 1'b0;
      rd_en      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (in_wr_i && ctrl_nz) begin
               mem_we   = 1'b1;
               wr_cnt_d = CNT_ONE;
               pay_d    = 1'b0;
               state_d  = S_HDR;
            end
         end
         S_HDR: begin
            if (in_wr_i) begin
               if (buf_full) begin
                  pay_d   = !ctrl_nz;
                  state_d = S_OVFL;
               end else begin
                  mem_we   = 1'b1;
                  wr_cnt_d = wr_cnt_q + CNT_ONE;
                  if (!ctrl_nz) state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (in_wr_i) begin
               // An overflowing word that is itself the last word ends the packet here.
               if (buf_full && ctrl_nz) begin
                  ovfl_cnt_d = ovfl_cnt_q + 32'd1;
                  wr_cnt_d   = '0;
                  state_d    = S_IDLE;
               end else if (buf_full) begin
                  pay_d   = 1'b1;
                  state_d = S_OVFL;
               end else begin
                  mem_we   = 1'b1;
                  wr_cnt_d = wr_cnt_q + CNT_ONE;
                  if (ctrl_nz) state_d = S_HOLD;
               end
            end
         end
         S_OVFL: begin
            if (in_wr_i) begin
               if (!ctrl_nz) begin
                  pay_d = 1'b1;
               end else if (pay_q) begin
                  ovfl_cnt_d = ovfl_cnt_q + 32'd1;
                  wr_cnt_d   = '0;
                  state_d    = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            rd_ptr_d = '0;
            if (AUTO_RELEASE) begin
               state_d = S_SEND;
            end else if (cmd_drop_i) begin
               drop_cnt_d = drop_cnt_q + 32'd1;
               wr_cnt_d   = '0;
               state_d    = S_IDLE;
            end else if (cmd_release_i) begin
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (out_rdy_i && (rd_ptr_q != wr_cnt_q)) begin
               rd_en    = 1'b1;
               rd_ptr_d = rd_ptr_q + CNT_ONE;
            end
            if (out_wr_q && out_last_q) begin
               fwd_cnt_d = fwd_cnt_q + 32'd1;
               wr_cnt_d  = '0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_rdy_d   = (state_d == S_IDLE) || (state_d == S_HDR) ||
                   (state_d == S_PAYLOAD) || (state_d == S_OVFL);
      held_d     = (state_d == S_HOLD);
      held_len_d = held_d ? wr_cnt_d : '0;
   end

   assign in_rdy_o        = in_rdy_q;
   assign pkt_held_o      = held_q;
   assign held_len_o      = held_len_q;
   assign out_wr_o        = out_wr_q;
   assign out_ctrl_o      = out_word_q[WW-1:DATA_WIDTH];
   assign out_data_o      = out_word_q[DATA_WIDTH-1:0];
   assign cpu_rd_data_o   = cpu_word_q;
   assign pkt_fwd_cnt_o   = fwd_cnt_q;
   assign pkt_drop_cnt_o  = drop_cnt_q;
   assign ovfl_drop_cnt_o = ovfl_cnt_q;

endmodule

// File: tb/tb_pkt_hold_buffer.sv
// Bench for pkt_hold_buffer: one software-released and one auto-released instance, depth 8 words.
module tb_pkt_hold_buffer;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [63:0] in_data;
   logic [7:0]  in_ctrl;
   logic        in_wr_m, in_wr_a, out_rdy, cmd_rel, cmd_drop;
   logic [AW-1:0] cpu_addr;

   logic        in_rdy_m, out_wr_m, held_m, in_rdy_a, out_wr_a, held_a;
   logic [63:0] out_data_m, out_data_a;
   logic [7:0]  out_ctrl_m, out_ctrl_a;
   logic [AW:0] held_len_m, held_len_a;
   logic [71:0] cpu_m, cpu_a;
   logic [31:0] fwd_m, drop_m, ovfl_m, fwd_a, drop_a, ovfl_a;

   pkt_hold_buffer #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ADDR_WIDTH(AW), .AUTO_RELEASE(1'b0)) u_man (
      .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_ctrl_i(in_ctrl), .in_wr_i(in_wr_m),
      .in_rdy_o(in_rdy_m), .out_data_o(out_data_m), .out_ctrl_o(out_ctrl_m), .out_wr_o(out_wr_m),
      .out_rdy_i(out_rdy), .cmd_release_i(cmd_rel), .cmd_drop_i(cmd_drop), .pkt_held_o(held_m),
      .held_len_o(held_len_m), .cpu_addr_i(cpu_addr), .cpu_rd_data_o(cpu_m),
      .pkt_fwd_cnt_o(fwd_m), .pkt_drop_cnt_o(drop_m), .ovfl_drop_cnt_o(ovfl_m));

   pkt_hold_buffer #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ADDR_WIDTH(AW), .AUTO_RELEASE(1'b1)) u_auto (
      .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_ctrl_i(in_ctrl), .in_wr_i(in_wr_a),
      .in_rdy_o(in_rdy_a), .out_data_o(out_data_a), .out_ctrl_o(out_ctrl_a), .out_wr_o(out_wr_a),
      .out_rdy_i(out_rdy), .cmd_release_i(cmd_rel), .cmd_drop_i(cmd_drop), .pkt_held_o(held_a),
      .held_len_o(held_len_a), .cpu_addr_i(cpu_addr), .cpu_rd_data_o(cpu_a),
      .pkt_fwd_cnt_o(fwd_a), .pkt_drop_cnt_o(drop_a), .ovfl_drop_cnt_o(ovfl_a));

   int checks = 0;
   int failures = 0;
   int exp_fwd_m = 0, exp_drop_m = 0, exp_ovfl_m = 0;
   logic [71:0] exp_m[$];
   logic [71:0] exp_a[$];
   logic [71:0] cur_pkt[$];
   logic rdy_seen_m = 1'b0, rdy_seen_a = 1'b0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: every output word must match the oldest expected word.
   always @(negedge clk) begin
      rdy_seen_m <= in_rdy_m;
      rdy_seen_a <= in_rdy_a;
      if (rst_n) begin
         if (out_wr_m) begin
            if (exp_m.size() == 0) chk("man_unexpected_out_wr", out_wr_m, 0);
            else chk("man_out_word", {out_ctrl_m, out_data_m}, exp_m.pop_front());
         end
         if (out_wr_a) begin
            if (exp_a.size() == 0) chk("auto_unexpected_out_wr", out_wr_a, 0);
            else chk("auto_out_word", {out_ctrl_a, out_data_a}, exp_a.pop_front());
         end
      end
   end

   function automatic logic [7:0] rand_nz();
      logic [7:0] v;
      v = 8'($urandom_range(1, 255));
      return v;
   endfunction

   task automatic build_pkt(input int h, input int p, input logic [7:0] hc, input logic [7:0] lc);
      cur_pkt.delete();
      for (int i = 0; i < h; i++) cur_pkt.push_back({(hc != 0) ? hc : rand_nz(), $urandom, $urandom});
      for (int i = 0; i < p; i++) cur_pkt.push_back({8'h00, $urandom, $urandom});
      cur_pkt.push_back({(lc != 0) ? lc : rand_nz(), $urandom, $urandom});
   endtask

   // Writes cur_pkt, issuing a word only when in_rdy was high in the previous cycle.
   task automatic send_pkt(input bit sel);
      int i = 0;
      int guard = 0;
      logic rdy;
      while (i < cur_pkt.size() && guard < 400) begin
         @(posedge clk); #1;
         guard++;
         rdy = sel ? rdy_seen_a : rdy_seen_m;
         if (rdy && $urandom_range(0, 3) != 0) begin
            {in_ctrl, in_data} = cur_pkt[i];
            if (sel) in_wr_a = 1'b1; else in_wr_m = 1'b1;
            i++;
         end else begin
            in_wr_a = 1'b0;
            in_wr_m = 1'b0;
         end
      end
      if (i < cur_pkt.size()) chk("send_timeout_words", i, cur_pkt.size());
      @(posedge clk); #1;
      in_wr_a = 1'b0;
      in_wr_m = 1'b0;
   endtask

   task automatic pulse(input bit rel, input bit drp);
      @(posedge clk); #1;
      cmd_rel = rel; cmd_drop = drp;
      @(posedge clk); #1;
      cmd_rel = 1'b0; cmd_drop = 1'b0;
   endtask

   // action: 0 release (random out_rdy), 1 drop, 2 release+drop, 3 release with fixed out_rdy pattern
   task automatic run_manual(input int h, input int p, input logic [7:0] hc, input logic [7:0] lc,
                             input int action);
      int n, guard, issued;
      logic exp_wr;
      logic [6:0] pat;
      build_pkt(h, p, hc, lc);
      n = cur_pkt.size();
      send_pkt(0);
      @(negedge clk);
      if (n > DEPTH) begin
         exp_ovfl_m++;
         chk("ovfl_no_pkt_held", held_m, 0);
         chk("ovfl_drop_cnt", ovfl_m, exp_ovfl_m);
         chk("ovfl_in_rdy", in_rdy_m, 1);
         repeat (3) @(negedge clk);
         return;
      end
      chk("held_pkt_held", held_m, 1);
      chk("held_len", held_len_m, n);
      chk("held_in_rdy", in_rdy_m, 0);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         cpu_addr = AW'(i);
         @(posedge clk);
         @(negedge clk);
         chk("cpu_rd_data", cpu_m, cur_pkt[i]);
      end
      if (action == 1 || action == 2) begin
         pulse(action == 2, 1'b1);
         @(negedge clk);
         exp_drop_m++;
         chk("drop_cnt", drop_m, exp_drop_m);
         chk("drop_in_rdy", in_rdy_m, 1);
         chk("drop_held_cleared", held_len_m, 0);
         repeat (4) @(negedge clk);
         chk("drop_fwd_unchanged", fwd_m, exp_fwd_m);
      end else begin
         foreach (cur_pkt[i]) exp_m.push_back(cur_pkt[i]);
         exp_fwd_m++;
         out_rdy = 1'b0;
         pulse(1'b1, 1'b0);
         if (action == 3) begin
            pat = 7'b1011001;
            exp_wr = 1'b0;
            issued = 0;
            for (int j = 0; j < 12; j++) begin
               if (j > 0) begin @(posedge clk); #1; end
               out_rdy = (j < 7) ? pat[j] : 1'b1;
               @(negedge clk);
               chk("rdy_pattern_out_wr", out_wr_m, exp_wr);
               exp_wr = out_rdy && (issued < n);
               if (exp_wr) issued++;
            end
         end else begin
            guard = 0;
            out_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            while (!(exp_m.size() == 0 && in_rdy_m) && guard < 200) begin
               @(posedge clk); #1;
               out_rdy = 1'($urandom_range(0, 1));
               @(negedge clk);
               guard++;
            end
            chk("release_drain_left", exp_m.size(), 0);
         end
         out_rdy = 1'b1;
         chk("fwd_cnt", fwd_m, exp_fwd_m);
         chk("send_held_len_cleared", held_len_m, 0);
      end
   endtask

   initial begin
      int guard;
      rst_n = 1'b0; in_data = '0; in_ctrl = '0; in_wr_m = 1'b0; in_wr_a = 1'b0;
      out_rdy = 1'b1; cmd_rel = 1'b0; cmd_drop = 1'b0; cpu_addr = '0;
      @(negedge clk);
      chk("rst_in_rdy", in_rdy_m, 0);
      chk("rst_out_wr", out_wr_m, 0);
      chk("rst_pkt_held", held_m, 0);
      chk("rst_held_len", held_len_m, 0);
      chk("rst_counters", {fwd_m, drop_m, ovfl_m[7:0]}, 0);
      chk("rst_cpu_rd_data", cpu_m, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_rdy_man", in_rdy_m, 1);
      chk("post_rst_in_rdy_auto", in_rdy_a, 1);

      run_manual(1, 3, 8'hFF, 8'h08, 0);
      run_manual(1, 3, 8'hFF, 8'h08, 1);
      run_manual(1, 3, 8'hFF, 8'h08, 2);
      run_manual(1, 6, 8'hFF, 8'h08, 0);
      run_manual(1, 8, 8'hFF, 8'h08, 0);
      run_manual(1, 3, 8'hFF, 8'h08, 0);
      run_manual(1, 3, 8'hFF, 8'h08, 3);

      // Stray ctrl==0 word in IDLE must vanish without side effects.
      @(posedge clk); #1;
      in_ctrl = 8'h00; in_data = 64'hDEAD_BEEF_0000_0001; in_wr_m = 1'b1;
      @(posedge clk); #1;
      in_wr_m = 1'b0;
      @(negedge clk);
      chk("stray_in_rdy", in_rdy_m, 1);
      chk("stray_pkt_held", held_m, 0);
      chk("stray_counters", {fwd_m, drop_m}, {exp_fwd_m, exp_drop_m});
      run_manual(2, 2, 8'h00, 8'h00, 0);

      run_manual(9, 1, 8'h00, 8'h00, 0);
      run_manual(1, 7, 8'h00, 8'h00, 0);
      for (int k = 0; k < 20; k++)
         run_manual($urandom_range(1, 3), $urandom_range(1, 8), 8'h00, 8'h00, $urandom_range(0, 2));

      // Auto-release instance: three back-to-back packets.
      out_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) build_pkt(1, 3, 8'hFF, 8'h08);
         else build_pkt($urandom_range(1, 2), $urandom_range(1, 5), 8'h00, 8'h00);
         foreach (cur_pkt[i]) exp_a.push_back(cur_pkt[i]);
         send_pkt(1);
      end
      guard = 0;
      @(negedge clk);
      while (!(exp_a.size() == 0 && in_rdy_a) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk("auto_drain_left", exp_a.size(), 0);
      chk("auto_fwd_cnt", fwd_a, 3);
      chk("auto_drop_cnt", drop_a, 0);

      // Reset in the middle of an auto SEND.
      out_rdy = 1'b0;
      build_pkt(1, 3, 8'hFF, 8'h08);
      foreach (cur_pkt[i]) exp_a.push_back(cur_pkt[i]);
      send_pkt(1);
      repeat (3) @(posedge clk);
      #1 out_rdy = 1'b1;
      @(posedge clk); #2;
      chk("pre_reset_out_wr", out_wr_a, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_send_rst_out_wr", out_wr_a, 0);
      chk("mid_send_rst_fwd_auto", fwd_a, 0);
      chk("mid_send_rst_man_counters", {fwd_m, drop_m}, 0);
      chk("mid_send_rst_ovfl", ovfl_m, 0);
      chk("mid_send_rst_in_rdy", in_rdy_a, 0);
      exp_a.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("after_rst_in_rdy_auto", in_rdy_a, 1);
      chk("after_rst_out_wr_auto", out_wr_a, 0);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
